mult_share_arb: RTL

//  Shares one pipelined signed multiplier between NUM_REQ requesters.
//  - Round-robin arbiter accepts at most one operand pair per cycle.
//  - Tags the pair with the requester ID and returns the full-precision

---
 rtl/mult_share_arb_pkg.sv | 24 ++
 rtl/mult_share_arb_rr_arbiter.sv | 34 +++
 rtl/mult_share_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared constants and width helpers for the mult_share_arb block.
// Replaces the old mult_share_defs.vh header.
package mult_share_arb_pkg;

  localparam int unsigned MIN_NUM_REQ     = 2;
  localparam int unsigned MAX_NUM_REQ     = 16;
  localparam int unsigned MIN_PIPE_STAGES = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned c_width(input int unsigned a, input int unsigned b);
    return a + b;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i (with wrap)
// wins; grant is suppressed when en_i is low. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  input  logic                en_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] grant_idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == cand) && req_i[j]) begin
          found       = 1'b1;
          grant_o[j]  = en_i;
          grant_idx_o = ID_WIDTH'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one pipelined signed multiplier between NUM_REQ round-robin requesters.
// Optional output register: define MULT_SHARE_ARB_OUT_REG_EN (latency PIPE_STAGES+1).
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned B_WIDTH     = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]        req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]        req_b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [id_width(NUM_REQ)-1:0]      res_id,
  output logic [c_width(A_WIDTH,B_WIDTH)-1:0] res_product,
  output logic                              busy
);

  localparam int unsigned C_WIDTH  = c_width(A_WIDTH, B_WIDTH);
  localparam int unsigned ID_WIDTH = id_width(NUM_REQ);
  localparam int unsigned LAST     = PIPE_STAGES - 1;

  if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ || PIPE_STAGES < MIN_PIPE_STAGES)
  begin : g_bad_cfg
    $error("mult_share_arb: unsupported NUM_REQ or PIPE_STAGES");
  end

  logic                       stall;
  logic                       accept;
  logic                       out_rdy;
  logic [NUM_REQ-1:0]         grant;
  logic [ID_WIDTH-1:0]        grant_idx;
  logic [ID_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
  logic signed [A_WIDTH-1:0]  a_sel;
  logic signed [B_WIDTH-1:0]  b_sel;
  logic signed [C_WIDTH-1:0]  mult;

  logic [PIPE_STAGES-1:0]     stg_rdy;
  logic [PIPE_STAGES-1:0]     stg_vld_q, stg_vld_d;
  logic [ID_WIDTH-1:0]        stg_id_q   [PIPE_STAGES];
  logic [ID_WIDTH-1:0]        stg_id_d   [PIPE_STAGES];
  logic [C_WIDTH-1:0]         stg_prod_q [PIPE_STAGES];
  logic [C_WIDTH-1:0]         stg_prod_d [PIPE_STAGES];

  assign stall = res_valid & ~res_ready;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (~stall),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == ID_WIDTH'(j)) begin
        a_sel = req_a[j*A_WIDTH +: A_WIDTH];
        b_sel = req_b[j*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign mult = C_WIDTH'(a_sel) * C_WIDTH'(b_sel);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  // A stage may load when any stage at or after it is empty, or the output drains;
  // this lets bubbles collapse under stall without reordering.
  always_comb begin
    stg_rdy = '0;
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      stg_rdy[k] = out_rdy;
      for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
        if (j >= k && !stg_vld_q[j]) stg_rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_id_d   = stg_id_q;
    stg_prod_d = stg_prod_q;
    if (stg_rdy[0]) begin
      stg_vld_d[0]  = accept;
      stg_id_d[0]   = grant_idx;
      stg_prod_d[0] = mult;
    end
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      if (stg_rdy[k]) begin
        stg_vld_d[k]  = stg_vld_q[k-1];
        stg_id_d[k]   = stg_id_q[k-1];
        stg_prod_d[k] = stg_prod_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      stg_vld_q <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        stg_id_q[k]   <= '0;
        stg_prod_q[k] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_id_q   <= stg_id_d;
      stg_prod_q <= stg_prod_d;
    end
  end

`ifdef MULT_SHARE_ARB_OUT_REG_EN
  logic                out_vld_q, out_vld_d;
  logic                busy_q, busy_d;
  logic [ID_WIDTH-1:0] out_id_q, out_id_d;
  logic [C_WIDTH-1:0]  out_prod_q, out_prod_d;

  assign out_rdy = ~out_vld_q | res_ready;

  // busy is registered from next-state so it stays a pure flop output.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    out_prod_d = out_prod_q;
    if (out_rdy) begin
      out_vld_d  = stg_vld_q[LAST];
      out_id_d   = stg_id_q[LAST];
      out_prod_d = stg_prod_q[LAST];
    end
    busy_d = (|stg_vld_d) | out_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      out_prod_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      out_prod_q <= out_prod_d;
      busy_q     <= busy_d;
    end
  end

  assign res_valid   = out_vld_q;
  assign res_id      = out_id_q;
  assign res_product = out_prod_q;
  assign busy        = busy_q;
`else
  assign out_rdy     = res_ready;
  assign res_valid   = stg_vld_q[LAST];
  assign res_id      = stg_id_q[LAST];
  assign res_product = stg_prod_q[LAST];
  assign busy        = |stg_vld_q;
`endif

endmodule
